// File: rtl/fht_pkg.sv
// fht_pkg: shared constants and helpers for the FHT butterfly array.
//   fht_one / fht_round : twiddle unity (2**(W-2)) and rounding offset (2**(W-3)).
//   ONE / ROUND         : the same values for the default 12-bit twiddle.
//   sat()               : clip a wide signed value to a d_bit-wide signed range.
//   perm_src()          : which lane result drives each word of a 4-word output group.
package fht_pkg;

    localparam int FHT_W_BIT = 12;

    function automatic int fht_one(input int w_bit);
        return 1 << (w_bit - 2);
    endfunction

    function automatic int fht_round(input int w_bit);
        return 1 << (w_bit - 3);
    endfunction

    localparam int ONE   = fht_one(FHT_W_BIT);
    localparam int ROUND = fht_round(FHT_W_BIT);

    typedef logic signed [63:0] fht_wide_t;

    function automatic fht_wide_t sat(input fht_wide_t v, input int d_bit);
        fht_wide_t hi;
        fht_wide_t lo;
        hi = (fht_wide_t'(1) <<< (d_bit - 1)) - fht_wide_t'(1);
        lo = -hi - fht_wide_t'(1);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Sources inside one lane pair: A = even lane k, B = odd lane k+1.
    typedef enum logic [1:0] {
        SRC_Y0A = 2'd0,
        SRC_Y1A = 2'd1,
        SRC_Y0B = 2'd2,
        SRC_Y1B = 2'd3
    } perm_src_t;

    // Output word pos (0..3) of a pair group; the last stage wins over the
    // second-half swap.
    function automatic perm_src_t perm_src(input logic [1:0] pos, input logic st_last,
                                           input logic part2);
        perm_src_t src;
        src = SRC_Y0A;
        if (st_last) begin
            src = perm_src_t'(pos);
        end else if (part2) begin
            case (pos)
                2'd0:    src = SRC_Y0B;
                2'd1:    src = SRC_Y0A;
                2'd2:    src = SRC_Y1B;
                default: src = SRC_Y1A;
            endcase
        end else begin
            case (pos)
                2'd0:    src = SRC_Y0A;
                2'd1:    src = SRC_Y0B;
                2'd2:    src = SRC_Y1A;
                default: src = SRC_Y1B;
            endcase
        end
        return src;
    endfunction

endpackage

// File: rtl/fht_but_lane.sv
// fht_but_lane: one radix-2 FHT butterfly lane, pipeline stages S1..S3.
//   S1 registers operands and (possibly forced) twiddle, S2 the product sum,
//   S3 the rounded, reduced sum/difference.
// Ports:
//   i_clk, i_rst_n       clock, async active-low reset
//   i_en                 advance all stages
//   i_triv               force twiddle to cos=ONE, sin=0
//   i_x0, i_x1, i_x2     operands (X2 = partner lane's odd bank)
//   i_cos, i_sin         lane twiddle
//   o_y0, o_y1           X0+T, X0-T reduced to D_BIT
//   o_ovf                either result clipped (only with FHT_BUT_SAT_EN)
// Macro FHT_BUT_SAT_EN: saturate results; otherwise wrap modulo 2**D_BIT.
module fht_but_lane import fht_pkg::*; #(
    parameter int D_BIT = 17,
    parameter int W_BIT = 12
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic                    i_triv,
    input  logic signed [D_BIT-1:0] i_x0,
    input  logic signed [D_BIT-1:0] i_x1,
    input  logic signed [D_BIT-1:0] i_x2,
    input  logic signed [W_BIT-1:0] i_cos,
    input  logic signed [W_BIT-1:0] i_sin,
    output logic signed [D_BIT-1:0] o_y0,
    output logic signed [D_BIT-1:0] o_y1,
    output logic                    o_ovf
);
    localparam int PW = D_BIT + W_BIT + 1;
    localparam int SW = D_BIT + 2;
    localparam int SH = W_BIT - 2;
    localparam logic signed [W_BIT-1:0] C_ONE = W_BIT'(fht_one(W_BIT));
    localparam logic signed [PW-1:0]    C_RND = PW'(fht_round(W_BIT));

    logic signed [W_BIT-1:0] w_cos, w_sin;
    logic signed [D_BIT-1:0] r_x0_s1, r_x1_s1, r_x2_s1, r_x0_s2;
    logic signed [W_BIT-1:0] r_cos_s1, r_sin_s1;
    logic signed [PW-1:0]    w_p, r_p_s2, w_rnd;
    logic signed [SW-1:0]    w_t, w_y0, w_y1;
    logic signed [D_BIT-1:0] w_y0_red, w_y1_red, r_y0_s3, r_y1_s3;
    logic                    w_ovf, r_ovf_s3;

    assign w_cos = i_triv ? C_ONE : i_cos;
    assign w_sin = i_triv ? '0 : i_sin;

    assign w_p   = PW'(r_x1_s1) * PW'(r_cos_s1) + PW'(r_x2_s1) * PW'(r_sin_s1);
    // Arithmetic shift floors, so adding half an LSB first rounds half up.
    assign w_rnd = r_p_s2 + C_RND;
    assign w_t   = SW'(w_rnd >>> SH);
    assign w_y0  = SW'(r_x0_s2) + w_t;
    assign w_y1  = SW'(r_x0_s2) - w_t;

`ifdef FHT_BUT_SAT_EN
    assign w_y0_red = D_BIT'(sat(fht_wide_t'(w_y0), D_BIT));
    assign w_y1_red = D_BIT'(sat(fht_wide_t'(w_y1), D_BIT));
    assign w_ovf    = (sat(fht_wide_t'(w_y0), D_BIT) != fht_wide_t'(w_y0)) ||
                      (sat(fht_wide_t'(w_y1), D_BIT) != fht_wide_t'(w_y1));
`else
    assign w_y0_red = D_BIT'(w_y0);
    assign w_y1_red = D_BIT'(w_y1);
    assign w_ovf    = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x0_s1  <= '0;
            r_x1_s1  <= '0;
            r_x2_s1  <= '0;
            r_cos_s1 <= '0;
            r_sin_s1 <= '0;
            r_p_s2   <= '0;
            r_x0_s2  <= '0;
            r_y0_s3  <= '0;
            r_y1_s3  <= '0;
            r_ovf_s3 <= 1'b0;
        end else if (i_en) begin
            r_x0_s1  <= i_x0;
            r_x1_s1  <= i_x1;
            r_x2_s1  <= i_x2;
            r_cos_s1 <= w_cos;
            r_sin_s1 <= w_sin;
            r_p_s2   <= w_p;
            r_x0_s2  <= r_x0_s1;
            r_y0_s3  <= w_y0_red;
            r_y1_s3  <= w_y1_red;
            r_ovf_s3 <= w_ovf;
        end
    end

    assign o_y0  = r_y0_s3;
    assign o_y1  = r_y1_s3;
    assign o_ovf = r_ovf_s3;

endmodule

// File: rtl/fht_but_array.sv
// fht_but_array: N_BUT-lane radix-2 FHT butterfly array, 4-stage pipeline.
//   Lanes (S1..S3) are fht_but_lane instances; this level carries valid and the
//   permutation flags alongside the data, registers the permuted output (S4)
//   and keeps the sticky overflow flag.
// Ports:
//   iCLK, iRESET          clock, async active-low reset
//   iEN                   advance every stage (0 freezes the pipe)
//   iVALID                input beat valid
//   iST_ZERO, iSECTOR     trivial twiddle when iST_ZERO=1 or iSECTOR=0
//   iST_LAST              identity output order
//   i2ND_PART_SUBSEC      lane-pair swap order
//   iBANK                 2*N_BUT words of D_BIT, bank b at [b*D_BIT +: D_BIT]
//   iSIN, iCOS            per-lane twiddles, lane k at [k*W_BIT +: W_BIT]
//   iCLR_OVF              clear sticky overflow (a simultaneous set wins)
//   oVALID, oY            output beat; oY holds while no valid beat arrives
//   oOVF                  sticky saturation flag
// Macro FHT_BUT_SAT_EN: saturating results and live oOVF; otherwise results
// wrap and oOVF is constant 0.
module fht_but_array import fht_pkg::*; #(
    parameter int D_BIT = 17,
    parameter int A_BIT = 8,
    parameter int W_BIT = 12,
    parameter int N_BUT = 2
) (
    input  logic                       iCLK,
    input  logic                       iRESET,
    input  logic                       iEN,
    input  logic                       iVALID,
    input  logic                       iST_ZERO,
    input  logic                       iST_LAST,
    input  logic                       i2ND_PART_SUBSEC,
    input  logic [A_BIT-1:0]           iSECTOR,
    input  logic [2*N_BUT*D_BIT-1:0]   iBANK,
    input  logic [N_BUT*W_BIT-1:0]     iSIN,
    input  logic [N_BUT*W_BIT-1:0]     iCOS,
    input  logic                       iCLR_OVF,
    output logic                       oVALID,
    output logic [2*N_BUT*D_BIT-1:0]   oY,
    output logic                       oOVF
);
    localparam int NB = 2 * N_BUT;

    logic                    w_triv;
    logic signed [D_BIT-1:0] w_y0 [N_BUT];
    logic signed [D_BIT-1:0] w_y1 [N_BUT];
    logic [N_BUT-1:0]        w_ovf;
    logic [NB*D_BIT-1:0]     w_perm;

    // Index 2 of each shift register is aligned with the lanes' S3 outputs.
    logic [2:0]              r_vld, r_last, r_part2;
    logic [NB*D_BIT-1:0]     r_y;
    logic                    r_vld_out;

    assign w_triv = iST_ZERO | (iSECTOR == '0);

    genvar gi;
    generate
        for (gi = 0; gi < N_BUT; gi++) begin : g_lane
            // X2 is the odd bank of the partner lane k^1, i.e. bank (2k+1)^2.
            fht_but_lane #(.D_BIT(D_BIT), .W_BIT(W_BIT)) u_lane (
                .i_clk   (iCLK),
                .i_rst_n (iRESET),
                .i_en    (iEN),
                .i_triv  (w_triv),
                .i_x0    (iBANK[(2*gi)*D_BIT +: D_BIT]),
                .i_x1    (iBANK[(2*gi+1)*D_BIT +: D_BIT]),
                .i_x2    (iBANK[((2*gi+1)^2)*D_BIT +: D_BIT]),
                .i_cos   (iCOS[gi*W_BIT +: W_BIT]),
                .i_sin   (iSIN[gi*W_BIT +: W_BIT]),
                .o_y0    (w_y0[gi]),
                .o_y1    (w_y1[gi]),
                .o_ovf   (w_ovf[gi])
            );
        end

        for (gi = 0; gi < NB; gi++) begin : g_perm
            localparam int         LA  = 2 * (gi / 4);
            localparam int         LB  = LA + 1;
            localparam logic [1:0] POS = 2'(gi % 4);
            perm_src_t w_src;
            assign w_src = perm_src(POS, r_last[2], r_part2[2]);
            assign w_perm[gi*D_BIT +: D_BIT] =
                (w_src == SRC_Y0A) ? w_y0[LA] :
                (w_src == SRC_Y1A) ? w_y1[LA] :
                (w_src == SRC_Y0B) ? w_y0[LB] : w_y1[LB];
        end
    endgenerate

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_vld     <= '0;
            r_last    <= '0;
            r_part2   <= '0;
            r_y       <= '0;
            r_vld_out <= 1'b0;
        end else if (iEN) begin
            r_vld     <= {r_vld[1:0], iVALID};
            r_last    <= {r_last[1:0], iST_LAST};
            r_part2   <= {r_part2[1:0], i2ND_PART_SUBSEC};
            r_vld_out <= r_vld[2];
            if (r_vld[2]) begin
                r_y <= w_perm;
            end
        end
    end

`ifdef FHT_BUT_SAT_EN
    logic r_ovf;
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_ovf <= 1'b0;
        end else if (iEN && r_vld[2] && (|w_ovf)) begin
            r_ovf <= 1'b1;
        end else if (iCLR_OVF) begin
            r_ovf <= 1'b0;
        end
    end
    assign oOVF = r_ovf;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = ^{w_ovf, iCLR_OVF};
    assign oOVF = 1'b0;
`endif

    assign oVALID = r_vld_out;
    assign oY     = r_y;

endmodule

// File: tb/tb_fht_but_array.sv
module tb_fht_but_array;
    localparam int D = 17, W = 12, A = 8;
    localparam int MAXV = (1 << (D - 1)) - 1;
    localparam int MINV = -(1 << (D - 1));
`ifdef FHT_BUT_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif
    localparam int V3_Y0 = SAT_ON ? 65535 : -2;
    localparam int V7_Y1 = SAT_ON ? -65536 : 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en, valid, st_zero, st_last, second, clr;
    logic [A-1:0] sector;
    logic [8*D-1:0] bank4;
    logic [4*D-1:0] bank2;
    logic [4*W-1:0] cos4, sin4;
    logic [2*W-1:0] cos2, sin2;
    logic vld2, vld4, ovf2, ovf4;
    logic [4*D-1:0] y2;
    logic [8*D-1:0] y4;

    assign bank2 = bank4[4*D-1:0];
    assign cos2  = cos4[2*W-1:0];
    assign sin2  = sin4[2*W-1:0];

    fht_but_array #(.D_BIT(D), .A_BIT(A), .W_BIT(W), .N_BUT(2)) u_dut2 (
        .iCLK(clk), .iRESET(rst_n), .iEN(en), .iVALID(valid), .iST_ZERO(st_zero),
        .iST_LAST(st_last), .i2ND_PART_SUBSEC(second), .iSECTOR(sector), .iBANK(bank2),
        .iSIN(sin2), .iCOS(cos2), .iCLR_OVF(clr), .oVALID(vld2), .oY(y2), .oOVF(ovf2));

    fht_but_array #(.D_BIT(D), .A_BIT(A), .W_BIT(W), .N_BUT(4)) u_dut4 (
        .iCLK(clk), .iRESET(rst_n), .iEN(en), .iVALID(valid), .iST_ZERO(st_zero),
        .iST_LAST(st_last), .i2ND_PART_SUBSEC(second), .iSECTOR(sector), .iBANK(bank4),
        .iSIN(sin4), .iCOS(cos4), .iCLR_OVF(clr), .oVALID(vld4), .oY(y4), .oOVF(ovf4));

    int checks = 0;
    int failures = 0;
    int bank[8];
    int tc[4];
    int ts[4];

    typedef struct { int oy[8]; bit ovf2; bit ovf4; int tag; } exp_t;
    typedef struct {
        int b[4]; int c0; int s0; int c1; int s1;
        bit stz; int sec; bit last; bit p2; int ey[4]; bit eovf;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [8*D-1:0] act, input logic [8*D-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stim();
        for (int i = 0; i < 8; i++) bank4[i*D +: D] = D'(bank[i]);
        for (int k = 0; k < 4; k++) begin
            cos4[k*W +: W] = W'(tc[k]);
            sin4[k*W +: W] = W'(ts[k]);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint reduce(input longint v, output bit clip);
        longint m, r;
        clip = 1'b0;
        if (SAT_ON) begin
            if (v > MAXV) begin clip = 1'b1; return MAXV; end
            if (v < MINV) begin clip = 1'b1; return MINV; end
            return v;
        end
        m = 2 * (longint'(MAXV) + 1);
        r = v % m;
        if (r < 0) r = r + m;
        if (r > MAXV) r = r - m;
        return r;
    endfunction

    // Reference: butterfly per lane from plain integer arithmetic, then the
    // output order written out per lane pair.
    function automatic exp_t model();
        exp_t e;
        longint y0[4], y1[4], p, t, c, s;
        bit clip[4];
        bit ca, cb, triv;
        triv = st_zero || (sector == 0);
        for (int k = 0; k < 4; k++) begin
            c = triv ? 1024 : tc[k];
            s = triv ? 0 : ts[k];
            p = longint'(bank[2*k+1]) * c + longint'(bank[2*(k^1)+1]) * s;
            t = floor_div(p + 512, 1024);
            y0[k] = reduce(bank[2*k] + t, ca);
            y1[k] = reduce(bank[2*k] - t, cb);
            clip[k] = ca | cb;
        end
        for (int pr = 0; pr < 2; pr++) begin
            int a, b, o;
            a = 2 * pr; b = a + 1; o = 4 * pr;
            if (st_last) begin
                e.oy[o] = int'(y0[a]); e.oy[o+1] = int'(y1[a]);
                e.oy[o+2] = int'(y0[b]); e.oy[o+3] = int'(y1[b]);
            end else if (second) begin
                e.oy[o] = int'(y0[b]); e.oy[o+1] = int'(y0[a]);
                e.oy[o+2] = int'(y1[b]); e.oy[o+3] = int'(y1[a]);
            end else begin
                e.oy[o] = int'(y0[a]); e.oy[o+1] = int'(y0[b]);
                e.oy[o+2] = int'(y1[a]); e.oy[o+3] = int'(y1[b]);
            end
        end
        e.ovf2 = clip[0] | clip[1];
        e.ovf4 = clip[0] | clip[1] | clip[2] | clip[3];
        e.tag = 0;
        return e;
    endfunction

    function automatic logic [8*D-1:0] pack_exp(input exp_t e, input int n);
        logic [8*D-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i*D +: D] = D'(e.oy[i]);
        return v;
    endfunction

    task automatic add_vec(input int b0, input int b1, input int b2, input int b3,
                           input int c0, input int s0, input int c1, input int s1,
                           input bit stz, input int sec, input bit last, input bit p2,
                           input int e0, input int e1, input int e2, input int e3,
                           input bit eovf);
        vec_t v;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
        v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1;
        v.stz = stz; v.sec = sec; v.last = last; v.p2 = p2;
        v.ey[0] = e0; v.ey[1] = e1; v.ey[2] = e2; v.ey[3] = e3;
        v.eovf = eovf;
        tbl.push_back(v);
    endtask

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < 4; i++) bank[i] = v.b[i];
        for (int i = 4; i < 8; i++) bank[i] = 0;
        tc[0] = v.c0; ts[0] = v.s0; tc[1] = v.c1; ts[1] = v.s1;
        tc[2] = 0; ts[2] = 0; tc[3] = 0; ts[3] = 0;
        st_zero = v.stz; sector = A'(v.sec); st_last = v.last; second = v.p2;
        apply_stim();
    endtask

    task automatic randomize_stim();
        for (int i = 0; i < 8; i++) bank[i] = int'($urandom_range(0, 131071)) - 65536;
        for (int k = 0; k < 4; k++) begin
            tc[k] = int'($urandom_range(0, 2048)) - 1024;
            ts[k] = int'($urandom_range(0, 2048)) - 1024;
        end
        st_zero = ($urandom_range(0, 3) == 0);
        sector  = A'($urandom_range(0, 3));
        st_last = ($urandom_range(0, 2) == 0);
        second  = $urandom_range(0, 1) == 1;
        apply_stim();
    endtask

    task automatic run_random(input int ncyc);
        exp_t sb[$];
        exp_t e;
        int en_cnt;
        bit e_ovf2, e_ovf4, due, en_b, saw_due;
        logic [4*D-1:0] pv2;
        logic [8*D-1:0] pv4;
        logic pvld;
        en_cnt = 0; e_ovf2 = 0; e_ovf4 = 0;
        for (int c = 0; c < ncyc + 6; c++) begin
            en_b = (c >= ncyc) || (!(c >= 30 && c < 33) && ($urandom_range(0, 4) != 0));
            randomize_stim();
            valid = (c < ncyc) && ($urandom_range(0, 3) != 0);
            clr = en_b && ($urandom_range(0, 9) == 0);
            en = en_b;
            if (en_b && valid) begin
                e = model();
                e.tag = en_cnt + 1;
                sb.push_back(e);
            end
            pv2 = y2; pv4 = y4; pvld = vld2;
            step();
            if (en_b) begin
                en_cnt++;
                saw_due = (sb.size() > 0);
                due = saw_due && (sb[0].tag + 3 == en_cnt);
                chk("rnd_valid2", vld2, due);
                chk("rnd_valid4", vld4, due);
                if (due) begin
                    e = sb.pop_front();
                    chk("rnd_y_n2", y2, pack_exp(e, 4));
                    chk("rnd_y_n4", y4, pack_exp(e, 8));
                    if (e.ovf2) e_ovf2 = 1; else if (clr) e_ovf2 = 0;
                    if (e.ovf4) e_ovf4 = 1; else if (clr) e_ovf4 = 0;
                    $display("beat t=%0d y_n2=%h y_n4=%h", en_cnt, y2, y4);
                end else if (clr) begin
                    e_ovf2 = 0; e_ovf4 = 0;
                end
            end else begin
                chk("stall_hold_y2", y2, pv2);
                chk("stall_hold_y4", y4, pv4);
                chk("stall_hold_vld", vld2, pvld);
            end
            chk("rnd_ovf2", ovf2, e_ovf2);
            chk("rnd_ovf4", ovf4, e_ovf4);
        end
        chk("rnd_drained", sb.size(), 0);
        en = 1; clr = 0; valid = 0;
    endtask

    initial begin
        logic [8*D-1:0] ev;
        bit saw;
        rst_n = 0; en = 1; valid = 0; clr = 0; st_zero = 0; st_last = 0; second = 0;
        sector = '0; bank4 = '0; cos4 = '0; sin4 = '0;
        for (int i = 0; i < 8; i++) bank[i] = 0;
        for (int k = 0; k < 4; k++) begin tc[k] = 0; ts[k] = 0; end

        // Records: banks 0..3, cos0, sin0, cos1, sin1, st_zero, sector, last, part2, oY[0..3], ovf
        add_vec(100, 200, 0, 0,     1024, 0, 1024, 0,    0, 5, 1, 0,  300, -100, 0, 0,  0);
        add_vec(0, 3, 0, 0,         512, 0, 512, 0,      0, 1, 1, 0,  2, -2, 0, 0,      0);
        add_vec(65535, 65535, 0, 0, 1024, 0, 1024, 0,    0, 2, 1, 0,  V3_Y0, 0, 0, 0,   SAT_ON);
        add_vec(10, 20, 30, 5,      7, 99, 7, 99,        0, 0, 1, 0,  30, -10, 35, 25,  0);
        add_vec(10, 20, 30, 5,      7, 99, 7, 99,        1, 4, 0, 1,  35, 30, 25, -10,  0);
        add_vec(10, 20, 30, 5,      7, 99, 7, 99,        0, 0, 0, 0,  30, 35, -10, 25,  0);
        add_vec(10, 20, 30, 5,      7, 99, 7, 99,        1, 9, 1, 1,  30, -10, 35, 25,  0);
        add_vec(0, 0, 0, 100,       0, 512, -1024, 0,    0, 3, 0, 0,  50, -100, -50, 100, 0);
        add_vec(0, -3, 0, 0,        512, 0, 1024, 0,     0, 2, 0, 1,  0, -1, 0, 1,      0);
        add_vec(-65536, 0, 0, 65535, 0, 1024, 0, 0,      0, 6, 1, 0,  -1, V7_Y1, 0, 0,  SAT_ON);

        step(); step();
        chk("reset_valid", vld2, 0);
        chk("reset_y", y2, 0);
        chk("reset_ovf", ovf2, 0);
        rst_n = 1;
        step();

        foreach (tbl[i]) begin
            clr = 1; valid = 0; step(); clr = 0;
            load_vec(tbl[i]);
            valid = 1; step(); valid = 0; step(); step();
            chk("vec_latency3", vld2, 0);
            step();
            chk("vec_valid", vld2, 1);
            ev = '0;
            for (int w = 0; w < 4; w++) ev[w*D +: D] = D'(tbl[i].ey[w]);
            chk($sformatf("vec%0d_y", i), y2, ev);
            chk($sformatf("vec%0d_ovf", i), ovf2, tbl[i].eovf);
            $display("vector %0d y=%h ovf=%0d", i, y2, ovf2);
        end

        // Sticky overflow, clear, and set winning over a same-cycle clear.
        load_vec(tbl[2]);
        clr = 1; step(); clr = 0;
        valid = 1; step(); valid = 0; step(); step(); step();
        chk("ovf_set", ovf2, SAT_ON);
        step();
        chk("ovf_sticky", ovf2, SAT_ON);
        clr = 1; step(); clr = 0;
        chk("ovf_clear", ovf2, 0);
        valid = 1; step(); valid = 0; step(); step();
        clr = 1; step(); clr = 0;
        chk("ovf_set_wins", ovf2, SAT_ON);
        $display("overflow sequence ovf=%0d", ovf2);
        clr = 1; step(); clr = 0;
        repeat (5) step();

        run_random(300);

        // Reset with two beats in flight.
        randomize_stim();
        valid = 1; step(); step(); valid = 0;
        #2 rst_n = 0;
        #1;
        chk("rst_mid_valid", vld2 | vld4, 0);
        chk("rst_mid_y2", y2, 0);
        chk("rst_mid_y4", y4, 0);
        @(posedge clk); #1;
        rst_n = 1;
        saw = 0;
        repeat (8) begin
            step();
            saw = saw | vld2 | vld4;
        end
        chk("rst_no_stale", saw, 0);
        $display("reset sequence done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
